// File: rtl/bitstream_decode.sv
// Serial stochastic-bitstream decoder: counts ones over a BITSTREAM-bit frame and maps the
// count back to a QUANT-bit two's-complement value. Define BITSTREAM_DECODE_SAT_EN to saturate.
module bitstream_decode #(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned QUANT     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  input  logic                         bit_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(BITSTREAM):0]   out_quota,
  output logic [QUANT-1:0]             out_data
);

  localparam int unsigned CntW = $clog2(BITSTREAM);
  localparam int unsigned Sh   = QUANT - CntW;

  localparam logic [CntW-1:0] LastBit = CntW'(BITSTREAM - 1);
  localparam logic [QUANT:0]  Bias    = (QUANT + 1)'(1) << (QUANT - 1);

  if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : gen_bad_bitstream
    $error("BITSTREAM must be a power of two");
  end
  if (QUANT < CntW) begin : gen_bad_quant
    $error("QUANT must be at least log2(BITSTREAM)");
  end

  typedef enum logic {StCount, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CntW:0]         ones_q, ones_d;
  logic                  out_valid_q, out_valid_d;
  logic [CntW:0]         out_quota_q, out_quota_d;
  logic [QUANT-1:0]      out_data_q, out_data_d;

  logic [CntW:0]         ones_sum;
  logic [QUANT:0]        quota_ext;
  logic [QUANT:0]        dec_full;
  logic [QUANT-1:0]      dec_data;

  assign ones_sum  = ones_q + (CntW + 1)'(bit_in);
  assign quota_ext = (QUANT + 1)'(ones_sum);
  // One spare bit so a full frame (+BIAS) is representable before truncation.
  assign dec_full  = (quota_ext << Sh) - Bias;

`ifdef BITSTREAM_DECODE_SAT_EN
  // Only quota == BITSTREAM can exceed BIAS-1; that case lands exactly on +BIAS.
  always_comb begin
    dec_data = dec_full[QUANT-1:0];
    if (!dec_full[QUANT] && dec_full[QUANT-1]) begin
      dec_data = {1'b0, {(QUANT - 1){1'b1}}};
    end
  end
`else
  logic unused_dec_msb;
  assign unused_dec_msb = dec_full[QUANT];
  assign dec_data       = dec_full[QUANT-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    out_valid_d = out_valid_q;
    out_quota_d = out_quota_q;
    out_data_d  = out_data_q;
    bit_ready   = 1'b0;
    unique case (state_q)
      StCount: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
          ones_d    = ones_sum;
          if (bit_cnt_q == LastBit) begin
            out_quota_d = ones_sum;
            out_data_d  = dec_data;
            out_valid_d = 1'b1;
            state_d     = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          bit_cnt_d   = '0;
          ones_d      = '0;
          state_d     = StCount;
        end
      end
      default: state_d = StCount;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCount;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_quota_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      out_quota_q <= out_quota_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_quota = out_quota_q;
  assign out_data  = out_data_q;

endmodule
